// File: rtl/lsu_stage.sv
// ---------------------------------------------------------------------------
// lsu_stage -- memory-access pipeline stage between execute and writeback.
//
// Accepts one instruction per valid/ready handshake. LOAD/STORE run a single
// pipelined Wishbone-style bus cycle with byte-lane selects. Load data is
// aligned and sign/zero-extended. All other opcodes retire one cycle after
// accept. Misaligned accesses trap without touching the bus. A flush kills
// the instruction; if the strobe has already been taken, the stage drains
// the outstanding ack before returning to IDLE.
//
// Optional feature macro: LSU_TIMEOUT_EN (bus watchdog, TIMEOUT_CYCLES).
//
// Ports:
//   me_clk, me_rst             clock, asynchronous active-low reset
//   me_i_valid / me_o_ready    upstream handshake
//   me_i_flush                 kill accepted / in-flight instruction
//   me_i_opcode, me_i_funct3   operation, access size/sign
//   me_i_alu_value             effective address or ALU result
//   me_i_rs2_data              store data
//   me_i_rd_addr               destination register
//   me_o_cyc/stb/we/addr/sel/wdata, me_i_rdata/ack/bus_stall   bus
//   me_o_wb_valid, me_o_rd_we, me_o_rd_addr, me_o_rd_data     writeback
//   me_o_misalign              one-cycle misaligned-access trap
//   me_o_bus_err               one-cycle watchdog timeout
//
// States:
//   IDLE  | ready for a new instruction
//   REQ   | cyc=stb=1, waiting for the bus to take the strobe
//   WAIT  | strobe taken, waiting for ack
//   DRAIN | flushed while outstanding, waiting for ack to discard
// ---------------------------------------------------------------------------
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 7
`endif
`ifndef LOAD
`define LOAD   7'b0000011
`endif
`ifndef STORE
`define STORE  7'b0100011
`endif
`ifndef RTYPE
`define RTYPE  7'b0110011
`endif
`ifndef ITYPE
`define ITYPE  7'b0010011
`endif
`ifndef JAL
`define JAL    7'b1101111
`endif
`ifndef JALR
`define JALR   7'b1100111
`endif
`ifndef LUI
`define LUI    7'b0110111
`endif
`ifndef AUIPC
`define AUIPC  7'b0010111
`endif

module lsu_stage #(
    parameter int DWIDTH         = 32,
    parameter int AWIDTH         = 32,
    parameter int RWIDTH         = 5,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     me_clk,
    input  logic                     me_rst,
    input  logic                     me_i_valid,
    output logic                     me_o_ready,
    input  logic                     me_i_flush,
    input  logic [`OPCODE_WIDTH-1:0] me_i_opcode,
    input  logic [2:0]               me_i_funct3,
    input  logic [DWIDTH-1:0]        me_i_alu_value,
    input  logic [DWIDTH-1:0]        me_i_rs2_data,
    input  logic [RWIDTH-1:0]        me_i_rd_addr,
    output logic                     me_o_cyc,
    output logic                     me_o_stb,
    output logic                     me_o_we,
    output logic [AWIDTH-1:0]        me_o_addr,
    output logic [DWIDTH/8-1:0]      me_o_sel,
    output logic [DWIDTH-1:0]        me_o_wdata,
    input  logic [DWIDTH-1:0]        me_i_rdata,
    input  logic                     me_i_ack,
    input  logic                     me_i_bus_stall,
    output logic                     me_o_wb_valid,
    output logic                     me_o_rd_we,
    output logic [RWIDTH-1:0]        me_o_rd_addr,
    output logic [DWIDTH-1:0]        me_o_rd_data,
    output logic                     me_o_misalign,
    output logic                     me_o_bus_err
);

    localparam int NB = DWIDTH / 8;
    localparam int OW = $clog2(NB);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;

    state_t                     r_state;
    logic                       r_ready;
    logic                       r_cyc;
    logic                       r_stb;
    logic                       r_we;
    logic [`OPCODE_WIDTH-1:0]   r_opcode;
    logic [2:0]                 r_funct3;
    logic [AWIDTH-1:0]          r_addr;
    logic [DWIDTH-1:0]          r_rs2;
    logic [RWIDTH-1:0]          r_rd;
    logic                       r_wb_valid;
    logic                       r_rd_we;
    logic [RWIDTH-1:0]          r_rd_addr;
    logic [DWIDTH-1:0]          r_rd_data;
    logic                       r_misalign;
    logic                       r_bus_err;

    // ---------------- accept-side decode ----------------
    logic [AWIDTH-1:0] w_in_addr;
    logic [2:0]        w_low_mask;
    logic              w_is_mem;
    logic              w_is_store;
    logic              w_is_alu;
    logic              w_misalign;
    logic              w_accept;

    assign w_in_addr  = AWIDTH'(me_i_alu_value);
    assign w_is_store = (me_i_opcode == `STORE);
    assign w_is_mem   = (me_i_opcode == `LOAD) || w_is_store;
    assign w_is_alu   = (me_i_opcode == `RTYPE) || (me_i_opcode == `ITYPE) ||
                        (me_i_opcode == `JAL)   || (me_i_opcode == `JALR)  ||
                        (me_i_opcode == `LUI)   || (me_i_opcode == `AUIPC);
    assign w_accept   = me_i_valid && r_ready && !me_i_flush;

    always_comb begin
        w_low_mask = 3'd0;
        case (me_i_funct3[1:0])
            2'd0: w_low_mask = 3'd0;
            2'd1: w_low_mask = 3'd1;
            2'd2: w_low_mask = 3'd3;
            2'd3: w_low_mask = 3'd7;
            default: w_low_mask = 3'd0;
        endcase
    end

    // A doubleword access has no legal encoding on a 32-bit bus.
    assign w_misalign = (|(w_in_addr[2:0] & w_low_mask)) ||
                        ((DWIDTH == 32) && (me_i_funct3[1:0] == 2'd3));

    // ---------------- bus-side datapath (from captured registers) ----------------
    logic [OW-1:0]     w_off;
    logic [7:0]        w_sel_base;
    logic [15:0]       w_sel_wide;
    logic [DWIDTH-1:0] w_wdata;
    logic              w_is_load;

    assign w_off     = r_addr[OW-1:0];
    assign w_is_load = (r_opcode == `LOAD);

    always_comb begin
        w_sel_base = 8'h00;
        case (r_funct3[1:0])
            2'd0: w_sel_base = 8'h01;
            2'd1: w_sel_base = 8'h03;
            2'd2: w_sel_base = 8'h0F;
            2'd3: w_sel_base = 8'hFF;
            default: w_sel_base = 8'h00;
        endcase
    end

    assign w_sel_wide = {8'h00, w_sel_base} << w_off;

    // Replicating the access-sized chunk across every lane already places it
    // at any aligned offset, so no separate shift is needed.
    always_comb begin
        int rep_mask;
        w_wdata  = '0;
        rep_mask = (1 << r_funct3[1:0]) - 1;
        for (int i = 0; i < NB; i++) begin
            w_wdata[i*8 +: 8] = r_rs2[(i & rep_mask)*8 +: 8];
        end
    end

    assign me_o_cyc   = r_cyc;
    assign me_o_stb   = r_stb;
    assign me_o_we    = r_we;
    assign me_o_addr  = r_cyc ? {r_addr[AWIDTH-1:OW], {OW{1'b0}}} : '0;
    assign me_o_sel   = r_cyc ? w_sel_wide[NB-1:0] : '0;
    assign me_o_wdata = r_we ? w_wdata : '0;

    // ---------------- load alignment / extension ----------------
    // Shift the addressed bytes to the bottom, push them to the top, then
    // shift back down logically or arithmetically to extend.
    logic [DWIDTH-1:0]        w_rshift;
    logic [6:0]               w_ext_sh;
    logic [DWIDTH-1:0]        w_left;
    logic signed [DWIDTH-1:0] w_sra;
    logic [DWIDTH-1:0]        w_load_data;

    assign w_rshift    = me_i_rdata >> {w_off, 3'b000};
    assign w_ext_sh    = 7'(DWIDTH) - (7'd8 << r_funct3[1:0]);
    assign w_left      = w_rshift << w_ext_sh;
    assign w_sra       = $signed(w_left) >>> w_ext_sh;
    assign w_load_data = r_funct3[2] ? (w_left >> w_ext_sh) : w_sra;

    // ---------------- watchdog ----------------
    logic w_timeout;

`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_cnt;

    always_ff @(posedge me_clk or negedge me_rst) begin
        if (!me_rst) begin
            r_cnt <= '0;
        end else if (r_state == S_IDLE) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state != S_IDLE) && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // ---------------- end-of-transaction decode ----------------
    logic w_ack_ok;
    logic w_end;
    logic w_retire;
    logic w_err;

    // An ack only counts once the strobe has been (or is being) taken.
    assign w_ack_ok = me_i_ack &&
                      ((r_state == S_WAIT) || (r_state == S_DRAIN) ||
                       ((r_state == S_REQ) && !me_i_bus_stall));
    assign w_end    = (r_state != S_IDLE) &&
                      (w_ack_ok || w_timeout ||
                       ((r_state == S_REQ) && me_i_bus_stall && me_i_flush));
    assign w_retire = w_ack_ok && !me_i_flush && (r_state != S_DRAIN);
    assign w_err    = !w_ack_ok && w_timeout && (r_state != S_DRAIN);

    // ---------------- FSM ----------------
    always_ff @(posedge me_clk or negedge me_rst) begin
        if (!me_rst) begin
            r_state    <= S_IDLE;
            r_ready    <= 1'b0;
            r_cyc      <= 1'b0;
            r_stb      <= 1'b0;
            r_we       <= 1'b0;
            r_opcode   <= '0;
            r_funct3   <= '0;
            r_addr     <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_wb_valid <= 1'b0;
            r_rd_we    <= 1'b0;
            r_rd_addr  <= '0;
            r_rd_data  <= '0;
            r_misalign <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            r_rd_we    <= 1'b0;
            r_misalign <= 1'b0;
            r_bus_err  <= 1'b0;

            if (w_end) begin
                r_state   <= S_IDLE;
                r_ready   <= 1'b1;
                r_cyc     <= 1'b0;
                r_stb     <= 1'b0;
                r_we      <= 1'b0;
                r_bus_err <= w_err;
                if (w_retire) begin
                    r_wb_valid <= 1'b1;
                    r_rd_we    <= w_is_load && (r_rd != '0);
                    r_rd_addr  <= r_rd;
                    r_rd_data  <= w_is_load ? w_load_data : '0;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_ready <= 1'b1;
                        if (w_accept) begin
                            r_opcode <= me_i_opcode;
                            r_funct3 <= me_i_funct3;
                            r_addr   <= w_in_addr;
                            r_rs2    <= me_i_rs2_data;
                            r_rd     <= me_i_rd_addr;
                            if (!w_is_mem) begin
                                r_wb_valid <= 1'b1;
                                r_rd_we    <= w_is_alu && (me_i_rd_addr != '0);
                                r_rd_addr  <= me_i_rd_addr;
                                r_rd_data  <= me_i_alu_value;
                            end else if (w_misalign) begin
                                r_misalign <= 1'b1;
                            end else begin
                                r_state <= S_REQ;
                                r_ready <= 1'b0;
                                r_cyc   <= 1'b1;
                                r_stb   <= 1'b1;
                                r_we    <= w_is_store;
                            end
                        end
                    end
                    S_REQ: begin
                        if (!me_i_bus_stall) begin
                            r_stb   <= 1'b0;
                            r_state <= me_i_flush ? S_DRAIN : S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (me_i_flush) begin
                            r_state <= S_DRAIN;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign me_o_ready    = r_ready;
    assign me_o_wb_valid = r_wb_valid;
    assign me_o_rd_we    = r_rd_we;
    assign me_o_rd_addr  = r_rd_addr;
    assign me_o_rd_data  = r_rd_data;
    assign me_o_misalign = r_misalign;
`ifdef LSU_TIMEOUT_EN
    assign me_o_bus_err  = r_bus_err;
`else
    assign me_o_bus_err  = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_stage.sv
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 7
`endif
`ifndef LOAD
`define LOAD   7'b0000011
`endif
`ifndef STORE
`define STORE  7'b0100011
`endif
`ifndef RTYPE
`define RTYPE  7'b0110011
`endif
`ifndef ITYPE
`define ITYPE  7'b0010011
`endif

module tb_lsu_stage;

    logic        me_clk = 1'b0;
    logic        me_rst;
    logic        me_i_valid;
    logic        me_o_ready;
    logic        me_i_flush;
    logic [6:0]  me_i_opcode;
    logic [2:0]  me_i_funct3;
    logic [31:0] me_i_alu_value;
    logic [31:0] me_i_rs2_data;
    logic [4:0]  me_i_rd_addr;
    logic        me_o_cyc, me_o_stb, me_o_we;
    logic [31:0] me_o_addr;
    logic [3:0]  me_o_sel;
    logic [31:0] me_o_wdata;
    logic [31:0] me_i_rdata;
    logic        me_i_ack;
    logic        me_i_bus_stall;
    logic        me_o_wb_valid;
    logic        me_o_rd_we;
    logic [4:0]  me_o_rd_addr;
    logic [31:0] me_o_rd_data;
    logic        me_o_misalign;
    logic        me_o_bus_err;

    lsu_stage #(.DWIDTH(32), .AWIDTH(32), .RWIDTH(5), .TIMEOUT_CYCLES(8)) dut (
        .me_clk(me_clk), .me_rst(me_rst),
        .me_i_valid(me_i_valid), .me_o_ready(me_o_ready), .me_i_flush(me_i_flush),
        .me_i_opcode(me_i_opcode), .me_i_funct3(me_i_funct3),
        .me_i_alu_value(me_i_alu_value), .me_i_rs2_data(me_i_rs2_data),
        .me_i_rd_addr(me_i_rd_addr),
        .me_o_cyc(me_o_cyc), .me_o_stb(me_o_stb), .me_o_we(me_o_we),
        .me_o_addr(me_o_addr), .me_o_sel(me_o_sel), .me_o_wdata(me_o_wdata),
        .me_i_rdata(me_i_rdata), .me_i_ack(me_i_ack), .me_i_bus_stall(me_i_bus_stall),
        .me_o_wb_valid(me_o_wb_valid), .me_o_rd_we(me_o_rd_we),
        .me_o_rd_addr(me_o_rd_addr), .me_o_rd_data(me_o_rd_data),
        .me_o_misalign(me_o_misalign), .me_o_bus_err(me_o_bus_err)
    );

    always #5 me_clk = ~me_clk;

    // flags = {wb_valid, misalign, bus_err}
    typedef struct {
        logic [2:0]  flags;
        logic        rd_we;
        logic        chk;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [2:0] flags, input logic rd_we, input logic chk,
                        input logic [4:0] rd, input logic [31:0] data);
        exp_t e;
        e.flags = flags; e.rd_we = rd_we; e.chk = chk; e.rd = rd; e.data = data;
        sb.push_back(e);
    endtask

    // Retire monitor: every result pulse must match the oldest expectation.
    always @(negedge me_clk) begin
        exp_t e;
        if (me_rst === 1'b1 && (me_o_wb_valid || me_o_misalign || me_o_bus_err)) begin
            if (sb.size() == 0) begin
                check("unexpected_result", {61'd0, me_o_wb_valid, me_o_misalign, me_o_bus_err}, 64'd0);
            end else begin
                e = sb.pop_front();
                check("result_flags", {61'd0, me_o_wb_valid, me_o_misalign, me_o_bus_err}, {61'd0, e.flags});
                check("result_rd_we", {63'd0, me_o_rd_we}, {63'd0, e.rd_we});
                if (e.chk) begin
                    check("result_rd_addr", {59'd0, me_o_rd_addr}, {59'd0, e.rd});
                    check("result_rd_data", {32'd0, me_o_rd_data}, {32'd0, e.data});
                end
            end
        end
    end

    task automatic tick();
        @(negedge me_clk);
        #1;
    endtask

    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] rs2, input logic [4:0] rd);
        check("ready_before_issue", {63'd0, me_o_ready}, 64'd1);
        me_i_valid = 1'b1; me_i_opcode = op; me_i_funct3 = f3;
        me_i_alu_value = alu; me_i_rs2_data = rs2; me_i_rd_addr = rd;
        tick();
        me_i_valid = 1'b0;
    endtask

    task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata,
                           input logic [4:0] rd, input logic [31:0] expd, input int wait_cycles);
        push(3'b100, rd != 5'd0, 1'b1, rd, expd);
        issue(`LOAD, f3, addr, 32'd0, rd);
        check("load_cyc", {63'd0, me_o_cyc}, 64'd1);
        check("load_we", {63'd0, me_o_we}, 64'd0);
        for (int i = 0; i < wait_cycles; i++) tick();
        if (wait_cycles > 0) begin
            check("load_wait_stb", {63'd0, me_o_stb}, 64'd0);
            check("load_wait_cyc", {63'd0, me_o_cyc}, 64'd1);
        end
        me_i_rdata = rdata; me_i_ack = 1'b1;
        tick();
        me_i_ack = 1'b0; me_i_rdata = 32'd0;
        check("load_done_cyc", {63'd0, me_o_cyc}, 64'd0);
    endtask

    initial begin
        me_rst = 1'b0; me_i_valid = 1'b0; me_i_flush = 1'b0; me_i_opcode = '0;
        me_i_funct3 = '0; me_i_alu_value = '0; me_i_rs2_data = '0; me_i_rd_addr = '0;
        me_i_rdata = '0; me_i_ack = 1'b0; me_i_bus_stall = 1'b0;

        // reset state
        repeat (3) tick();
        check("rst_ready", {63'd0, me_o_ready}, 64'd0);
        check("rst_cyc", {63'd0, me_o_cyc}, 64'd0);
        check("rst_sel", {60'd0, me_o_sel}, 64'd0);
        check("rst_wb_valid", {63'd0, me_o_wb_valid}, 64'd0);
        me_rst = 1'b1;
        tick();
        check("post_rst_ready", {63'd0, me_o_ready}, 64'd1);

        // non-memory pass-through
        push(3'b100, 1'b1, 1'b1, 5'd5, 32'h0000_1234);
        issue(`ITYPE, 3'd0, 32'h0000_1234, 32'd0, 5'd5);
        push(3'b100, 1'b0, 1'b1, 5'd0, 32'h0000_1234);
        issue(`ITYPE, 3'd0, 32'h0000_1234, 32'd0, 5'd0);
        push(3'b100, 1'b0, 1'b0, 5'd0, 32'd0);
        issue(7'b0001111, 3'd0, 32'h55, 32'd0, 5'd9);

        // misaligned accesses
        push(3'b010, 1'b0, 1'b0, 5'd0, 32'd0);
        issue(`LOAD, 3'd2, 32'h0000_0101, 32'd0, 5'd3);
        check("mis_cyc", {63'd0, me_o_cyc}, 64'd0);
        check("mis_ready", {63'd0, me_o_ready}, 64'd1);
        tick();
        check("mis_cyc_later", {63'd0, me_o_cyc}, 64'd0);
        push(3'b010, 1'b0, 1'b0, 5'd0, 32'd0);
        issue(`STORE, 3'd1, 32'h0000_0103, 32'd0, 5'd0);
        push(3'b010, 1'b0, 1'b0, 5'd0, 32'd0);
        issue(`LOAD, 3'd3, 32'h0000_0100, 32'd0, 5'd3);

        // SB with ack in the cycle after accept
        push(3'b100, 1'b0, 1'b0, 5'd0, 32'd0);
        issue(`STORE, 3'd0, 32'h0000_0103, 32'h0000_00AB, 5'd0);
        check("sb_cyc_stb", {62'd0, me_o_cyc, me_o_stb}, 64'd3);
        check("sb_we", {63'd0, me_o_we}, 64'd1);
        check("sb_sel", {60'd0, me_o_sel}, 64'h8);
        check("sb_addr", {32'd0, me_o_addr}, 64'h100);
        check("sb_wdata", {32'd0, me_o_wdata}, 64'hABAB_ABAB);
        me_i_ack = 1'b1;
        tick();
        me_i_ack = 1'b0;
        check("sb_done_cyc", {63'd0, me_o_cyc}, 64'd0);
        check("sb_done_ready", {63'd0, me_o_ready}, 64'd1);

        // SH upper half
        push(3'b100, 1'b0, 1'b0, 5'd0, 32'd0);
        issue(`STORE, 3'd1, 32'h0000_0102, 32'h1234_CDEF, 5'd0);
        check("sh_sel", {60'd0, me_o_sel}, 64'hC);
        check("sh_wdata", {32'd0, me_o_wdata}, 64'hCDEF_CDEF);
        me_i_ack = 1'b1;
        tick();
        me_i_ack = 1'b0;

        // loads with extension
        do_load(3'd0, 32'h0000_0102, 32'h0080_0000, 5'd1, 32'hFFFF_FF80, 0);
        do_load(3'd4, 32'h0000_0102, 32'h0080_0000, 5'd1, 32'h0000_0080, 0);
        do_load(3'd1, 32'h0000_0102, 32'h8001_0000, 5'd2, 32'hFFFF_8001, 0);
        do_load(3'd5, 32'h0000_0100, 32'h1234_F00D, 5'd9, 32'h0000_F00D, 2);
        do_load(3'd2, 32'h0000_0104, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1);
        do_load(3'd0, 32'h0000_0101, 32'h0000_7F00, 5'd7, 32'h0000_007F, 0);

        // stall for 3 cycles, then flush in WAIT, ack 2 cycles later
        me_i_bus_stall = 1'b1;
        issue(`LOAD, 3'd2, 32'h0000_0200, 32'd0, 5'd4);
        check("stall_cyc_stb", {62'd0, me_o_cyc, me_o_stb}, 64'd3);
        check("stall_addr", {32'd0, me_o_addr}, 64'h200);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold_stb", {63'd0, me_o_stb}, 64'd1);
            check("stall_hold_addr", {32'd0, me_o_addr}, 64'h200);
            check("stall_hold_sel", {60'd0, me_o_sel}, 64'hF);
        end
        me_i_bus_stall = 1'b0;
        tick();
        check("wait_stb", {62'd0, me_o_cyc, me_o_stb}, 64'd2);
        me_i_flush = 1'b1;
        tick();
        me_i_flush = 1'b0;
        check("drain_cyc", {63'd0, me_o_cyc}, 64'd1);
        check("drain_ready", {63'd0, me_o_ready}, 64'd0);
        tick();
        check("drain_cyc_2", {63'd0, me_o_cyc}, 64'd1);
        me_i_rdata = 32'h1111_1111; me_i_ack = 1'b1;
        tick();
        me_i_ack = 1'b0; me_i_rdata = 32'd0;
        check("drain_done_cyc", {63'd0, me_o_cyc}, 64'd0);
        check("drain_done_ready", {63'd0, me_o_ready}, 64'd1);
        check("drain_no_wb", {63'd0, me_o_wb_valid}, 64'd0);

        // flush in REQ while stalled
        me_i_bus_stall = 1'b1;
        issue(`LOAD, 3'd2, 32'h0000_0300, 32'd0, 5'd4);
        me_i_flush = 1'b1;
        tick();
        me_i_flush = 1'b0; me_i_bus_stall = 1'b0;
        check("reqflush_cyc_stb", {62'd0, me_o_cyc, me_o_stb}, 64'd0);
        check("reqflush_ready", {63'd0, me_o_ready}, 64'd1);

        // flush in IDLE drops the instruction; ack in IDLE is ignored
        me_i_valid = 1'b1; me_i_flush = 1'b1; me_i_opcode = `ITYPE; me_i_rd_addr = 5'd6;
        tick();
        me_i_valid = 1'b0; me_i_flush = 1'b0;
        check("idleflush_wb", {63'd0, me_o_wb_valid}, 64'd0);
        me_i_ack = 1'b1;
        tick();
        me_i_ack = 1'b0;
        check("idle_ack_wb", {63'd0, me_o_wb_valid}, 64'd0);
        check("idle_ack_cyc", {63'd0, me_o_cyc}, 64'd0);

        // flush and ack together in WAIT: result discarded
        issue(`LOAD, 3'd2, 32'h0000_0400, 32'd0, 5'd8);
        tick();
        me_i_flush = 1'b1; me_i_ack = 1'b1; me_i_rdata = 32'h2222_2222;
        tick();
        me_i_flush = 1'b0; me_i_ack = 1'b0; me_i_rdata = 32'd0;
        check("flushack_cyc", {63'd0, me_o_cyc}, 64'd0);
        check("flushack_wb", {63'd0, me_o_wb_valid}, 64'd0);
        check("flushack_ready", {63'd0, me_o_ready}, 64'd1);

        // no ack: watchdog or indefinite wait
`ifdef LSU_TIMEOUT_EN
        push(3'b001, 1'b0, 1'b0, 5'd0, 32'd0);
        issue(`LOAD, 3'd2, 32'h0000_0500, 32'd0, 5'd3);
        for (int i = 0; i < 7; i++) begin
            tick();
            check("to_cyc_high", {63'd0, me_o_cyc}, 64'd1);
        end
        tick();
        check("to_cyc_drop", {63'd0, me_o_cyc}, 64'd0);
        check("to_ready", {63'd0, me_o_ready}, 64'd1);
`else
        push(3'b100, 1'b1, 1'b1, 5'd3, 32'h1122_3344);
        issue(`LOAD, 3'd2, 32'h0000_0500, 32'd0, 5'd3);
        for (int i = 0; i < 12; i++) begin
            tick();
            check("noto_cyc_high", {63'd0, me_o_cyc}, 64'd1);
            check("noto_bus_err", {63'd0, me_o_bus_err}, 64'd0);
        end
        me_i_rdata = 32'h1122_3344; me_i_ack = 1'b1;
        tick();
        me_i_ack = 1'b0; me_i_rdata = 32'd0;
        check("noto_done_cyc", {63'd0, me_o_cyc}, 64'd0);
`endif

        // asynchronous reset in the middle of a bus cycle
        issue(`LOAD, 3'd2, 32'h0000_0600, 32'd0, 5'd2);
        check("arst_pre_cyc", {63'd0, me_o_cyc}, 64'd1);
        #2 me_rst = 1'b0;
        #1 check("arst_cyc_stb", {62'd0, me_o_cyc, me_o_stb}, 64'd0);
        check("arst_ready", {63'd0, me_o_ready}, 64'd0);
        tick();
        me_rst = 1'b1;
        tick();
        check("arst_post_ready", {63'd0, me_o_ready}, 64'd1);

        push(3'b100, 1'b1, 1'b1, 5'd31, 32'h0000_CAFE);
        issue(`RTYPE, 3'd0, 32'h0000_CAFE, 32'd0, 5'd31);

        tick();
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_stage.md
Name: lsu_stage

Overview:
- Parametrised successor to the current memory-access pipeline stage. Sits between execute and writeback.
- Accepts one instruction per valid/ready handshake. Runs a pipelined Wishbone-style bus cycle with byte-lane selects for LOAD/STORE. Aligns and sign/zero-extends load data.
- Passes ALU results of all other writeback opcodes straight through.
- Width-generic (32/64-bit lanes), traps misaligned accesses, and handles flush while a bus cycle is outstanding.

Parameters:
- DWIDTH, 32, data/bus width; 32 or 64 only.
- AWIDTH, 32, byte-address width.
- RWIDTH, 5, register-index width.
- TIMEOUT_CYCLES, 64, watchdog limit (used only with LSU_TIMEOUT_EN).

Ports:
- me_clk  in  1  clock
- me_rst  in  1  asynchronous active-low reset
- me_i_valid  in  1  upstream instruction valid
- me_o_ready  out  1  stage can accept
- me_i_flush  in  1  kill accepted/in-flight instruction
- me_i_opcode  in  `OPCODE_WIDTH  opcode
- me_i_funct3  in  3  access size/sign
- me_i_alu_value  in  DWIDTH  effective address or ALU result
- me_i_rs2_data  in  DWIDTH  store data
- me_i_rd_addr  in  RWIDTH  destination register
- me_o_cyc, me_o_stb, me_o_we  out  1 each  bus control
- me_o_addr  out  AWIDTH  bus address, low log2(DWIDTH/8) bits forced 0
- me_o_sel  out  DWIDTH/8  byte-lane enables
- me_o_wdata  out  DWIDTH  lane-aligned store data
- me_i_rdata  in  DWIDTH  bus read data
- me_i_ack  in  1  bus acknowledge
- me_i_bus_stall  in  1  bus cannot take stb this cycle
- me_o_wb_valid  out  1  one-cycle retire pulse
- me_o_rd_we  out  1  register write enable
- me_o_rd_addr  out  RWIDTH  destination
- me_o_rd_data  out  DWIDTH  result
- me_o_misalign  out  1  one-cycle misaligned-access trap pulse
- me_o_bus_err  out  1  one-cycle timeout pulse (tied 0 without LSU_TIMEOUT_EN)

Behaviour:
- Reset: all outputs 0; state IDLE; counter 0. me_o_ready is 0 during reset and 1 in IDLE after reset.
- Reset mid-cycle drops cyc/stb immediately (asynchronous) and discards the transaction.
- States: IDLE, REQ, WAIT, DRAIN.
- me_o_ready = (state==IDLE).
- Accept happens on valid && ready && !flush. Address, funct3, rs2, rd and opcode are captured in registers at accept.

Non-memory ops (`RTYPE/`ITYPE/`JAL/`JALR/`LUI/`AUIPC):
- Next cycle: wb_valid=1, rd_we=(rd_addr!=0), rd_data=alu_value. Latency 1; state stays IDLE.

Other opcodes:
- wb_valid=1, rd_we=0.

Alignment:
- Size is from funct3[1:0]: 0=byte, 1=half, 2=word, 3=dword.
- dword is legal only when DWIDTH=64; at DWIDTH=32 it is treated as misaligned.
- Misaligned when addr mod size != 0.
- On misalignment: the next cycle pulses misalign=1 with wb_valid=0. No bus cycle is issued; state stays IDLE.

Aligned LOAD/STORE:
- Go to REQ.
- REQ: cyc=stb=1. sel = ((1<<size)-1) << offset. For stores, wdata = rs2 replicated and shifted by offset*8; we=1 for STORE.
- stb is accepted when !bus_stall.
  - Accepted, ack same cycle: go to IDLE and retire.
  - Accepted, no ack: go to WAIT (cyc=1, stb=0).
  - Not accepted: stay in REQ with all bus outputs held stable.
- WAIT: on ack, go to IDLE and retire.
- Retire occurs in the cycle after ack:
  - Load: rdata shifted right by offset*8, then sign-extended (LB/LH/LW) or zero-extended (LBU/LHU/LWU). rd_we=(rd!=0).
  - Store: wb_valid=1, rd_we=0.

Flush:
- In IDLE: the incoming instruction is dropped.
- In REQ with stb not yet accepted: cyc/stb drop the next cycle; go to IDLE; no retire.
- In REQ when stb is accepted that cycle, or in WAIT: go to DRAIN. cyc stays 1 until ack; the result is discarded with no wb_valid; then IDLE.
- Flush and ack in the same cycle: result discarded.

Single outstanding transaction:
- ack in IDLE is ignored.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Enabled:
  - A counter clears on entering REQ and increments each cycle in REQ/WAIT/DRAIN.
  - When it reaches TIMEOUT_CYCLES: cyc/stb drop, state goes to IDLE, and bus_err pulses 1 for one cycle with wb_valid=0. In DRAIN the pulse is suppressed.
- Disabled: no counter; bus_err constant 0; the stage waits indefinitely.

Test Plan:
- DWIDTH=32, `ITYPE, alu=0x0000_1234, rd=5 -> next cycle wb_valid=1, rd_we=1, rd_data=0x1234; rd=0 gives rd_we=0.
- SB addr=0x103, rs2=0xAB, bus_stall=0, ack next cycle -> sel=4'b1000, wdata=0xABAB_ABAB, addr=0x100, we=1; retire with rd_we=0 two cycles after accept.
- LB addr=0x102, rdata=0x0080_0000 -> rd_data=0xFFFF_FF80; LBU same -> 0x0000_0080; LH addr=0x102, rdata=0x8001_0000 -> 0xFFFF_8001.
- LW addr=0x101 -> misalign pulse; cyc never asserted; ready stays 1.
- LW, bus_stall=1 for 3 cycles, flush in WAIT, ack 2 cycles later -> addr/sel stable while stalled; cyc held until ack; no wb_valid; ready returns 1 the cycle after ack.
- With LSU_TIMEOUT_EN, TIMEOUT_CYCLES=8, LW with no ack -> cyc drops and bus_err pulses 8 cycles after entering REQ; without the macro, cyc stays high.
